// File: rtl/pll_reset_ctrl_if.sv
// Bundle of the PLL lock/reset handshake and the controller's status outputs.
// The PLL side (or a bench) drives pll_locked/relock_req through the master
// modport; the controller consumes them through the slave modport.
// pll_locked is a level with no timing relation to refclk. relock_req is a
// one-cycle request that is acted on in the cycle it is seen. There is no
// back-pressure: every request is taken, and a held request keeps the PLL
// held in reset.
interface pll_reset_ctrl_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  state,
    input  retry_cnt,
    input  loss_cnt
  );

  modport slave (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output state,
    output retry_cnt,
    output loss_cnt
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset / lock qualification controller, clocked by the PLL reference
// clock. It pulses the PLL reset, waits for lock, requires lock to stay up
// for a qualification window, then releases the downstream system reset
// after a short delay. A lock timeout or a loss of lock in run restarts the
// whole sequence automatically.
module pll_reset_ctrl #(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int LOCK_STABLE   = 256,
  parameter int RELEASE_DELAY = 16,
  parameter int CNT_W         = 16
) (
  input  logic             refclk,
  input  logic             rst,
  pll_reset_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Terminal counts: the counter reads N-1 in the last cycle of an N-cycle phase.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       retry_q;
  logic [7:0]       loss_q;
  logic             retry_inc;
  logic             loss_inc;
  logic             lock_meta;
  logic             locked_s;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             ready_q;

  // Two-flop synchroniser for the asynchronous lock flag; nothing else
  // looks at the raw pll_locked.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // Next-state selection: relock request wins over every lock/timeout event.
  always_comb begin
    state_nxt = state_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (bus.relock_req) begin
      state_nxt = S_RESET;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_nxt = S_RESET;
            retry_inc = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s)                  state_nxt = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_nxt = S_RELEASE;
        end
        S_RELEASE: begin
          if (!locked_s)                  state_nxt = S_WAIT_LOCK;
          else if (cnt_q == RELEASE_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt = S_RESET;
            loss_inc  = 1'b1;
          end
        end
        default: state_nxt = S_RESET;
      endcase
    end
  end

  // State, phase counter, event counters and registered output decodes.
  // The outputs are decoded from the next state so that they always equal
  // a decode of the state register one cycle later, with no input path.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      // A relock while already in S_RESET restarts the pulse from zero.
      if ((state_nxt != state_q) || bus.relock_req) cnt_q <= '0;
      else                                          cnt_q <= cnt_q + 1'b1;
      if (retry_inc && (retry_q != 8'hFF)) retry_q <= retry_q + 8'd1;
      if (loss_inc && (loss_q != 8'hFF))   loss_q  <= loss_q + 8'd1;
      pll_rst_q <= (state_nxt == S_RESET);
      sys_rst_q <= (state_nxt != S_RUN);
      ready_q   <= (state_nxt == S_RUN);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule
